// File: rtl/j_shifter_pkg.sv
// Shared definitions for the multi-lane bit-serial image shifter:
// shift-code constants, FSM state encoding and the shift-code decoder.
package j_shifter_pkg;

  localparam logic [3:0] SHT_KEEP       = 4'd0;
  localparam logic [3:0] SHT_UP         = 4'd1;
  localparam logic [3:0] SHT_DOWN       = 4'd2;
  localparam logic [3:0] SHT_LEFT       = 4'd3;
  localparam logic [3:0] SHT_RIGHT      = 4'd4;
  localparam logic [3:0] SHT_RIGHT_UP   = 4'd5;
  localparam logic [3:0] SHT_RIGHT_DOWN = 4'd6;
  localparam logic [3:0] SHT_LEFT_DOWN  = 4'd7;
  localparam logic [3:0] SHT_LEFT_UP    = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } js_state_t;

  // Neighbour offset as one-hot direction flags; each axis is -1, 0 or +1.
  typedef struct packed {
    logic dy_neg;
    logic dy_pos;
    logic dx_neg;
    logic dx_pos;
  } js_offs_t;

  // Map a shift code to its (dx, dy) direction flags; unused codes act as KEEP.
  function automatic js_offs_t shift_decode(input logic [3:0] code);
    js_offs_t o;
    o = '0;
    case (code)
      SHT_UP:         o.dy_neg = 1'b1;
      SHT_DOWN:       o.dy_pos = 1'b1;
      SHT_LEFT:       o.dx_neg = 1'b1;
      SHT_RIGHT:      o.dx_pos = 1'b1;
      SHT_RIGHT_UP:   begin o.dx_pos = 1'b1; o.dy_neg = 1'b1; end
      SHT_RIGHT_DOWN: begin o.dx_pos = 1'b1; o.dy_pos = 1'b1; end
      SHT_LEFT_DOWN:  begin o.dx_neg = 1'b1; o.dy_pos = 1'b1; end
      SHT_LEFT_UP:    begin o.dx_neg = 1'b1; o.dy_neg = 1'b1; end
      default:        o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/js_pix_buf.sv
// Two-entry pixel FIFO between the fetch engine and the shift engine.
// The head entry stays resident while it is being serialised and is popped
// only after its last bit is accepted. Push and pop on a full buffer is legal.
module js_pix_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_q;
  logic             rd_q;
  logic [1:0]       cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_q];
  assign count   = cnt_q;

  // Write the storage slot selected by the write pointer.
  // NOTE: storage is deliberately not reset; pointers and count are, and an
  // entry is never read before it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  // Advance pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) wr_q <= ~wr_q;
      if (do_pop)  rd_q <= ~rd_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/j_shifter_mc.sv
// Multi-lane bit-serial image shifter. Walks an (H+1)x(W+1) row-major map,
// fetches the neighbour selected by a 9-way shift code and streams every lane
// LSB-first over a valid/ready interface.
// Optional build macro J_SHIFTER_MC_ZSKIP_EN: when defined, the skip bit at the
// top of sram_data forces the fetched pixel to zero; when undefined it is ignored.
module j_shifter_mc
  import j_shifter_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int LANES       = 4,
  parameter int SRAM_ADDR_W = 18,
  parameter int DIM_W       = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [3:0]               shift_ctrl,
  input  logic [SRAM_ADDR_W-1:0]   start_addr,
  input  logic [DIM_W-1:0]         img_w_m1,
  input  logic [DIM_W-1:0]         img_h_m1,
  output logic                     busy,
  output logic                     done,
  output logic                     sram_en,
  output logic [SRAM_ADDR_W-1:0]   sram_addr,
  input  logic [LANES*DATA_W:0]    sram_data,
  output logic                     ser_valid,
  input  logic                     ser_ready,
  output logic [LANES-1:0]         ser_bits
);

  localparam int PIX_W = LANES * DATA_W;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  js_state_t              state_q, state_nxt;
  js_offs_t               offs_q, offs_start;
  logic [DIM_W-1:0]       w_max_q, h_max_q, col_q, row_q;
  logic [SRAM_ADDR_W-1:0] ptr_q, ptr_init, row_step;
  logic                   pend_vld_q, pend_zero_q;
  logic [BIT_W-1:0]       bit_q;
  logic                   done_q, done_nxt;

  logic                   in_range, slot_free, issue, last_pix, accept, pix_zero;
  logic                   buf_push, buf_pop, buf_empty, buf_full;
  logic [PIX_W-1:0]       buf_head, push_data;
  logic [1:0]             buf_cnt;

  assign offs_start = shift_decode(shift_ctrl);
  assign row_step   = SRAM_ADDR_W'(img_w_m1) + SRAM_ADDR_W'(1);

  // First source address: start_addr + dy*(W+1) + dx, wrapping at the address width.
  always_comb begin
    ptr_init = start_addr;
    if (offs_start.dy_neg)      ptr_init = ptr_init - row_step;
    else if (offs_start.dy_pos) ptr_init = ptr_init + row_step;
    if (offs_start.dx_neg)      ptr_init = ptr_init - SRAM_ADDR_W'(1);
    else if (offs_start.dx_pos) ptr_init = ptr_init + SRAM_ADDR_W'(1);
  end

  assign in_range  = !(offs_q.dy_neg && (row_q == '0))     &&
                     !(offs_q.dy_pos && (row_q == h_max_q)) &&
                     !(offs_q.dx_neg && (col_q == '0))     &&
                     !(offs_q.dx_pos && (col_q == w_max_q));
  // One slot per pixel in the buffer or already in flight; never more than two.
  assign slot_free = (buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && !pend_vld_q);
  assign issue     = (state_q == ST_RUN) && slot_free;
  assign last_pix  = (row_q == h_max_q) && (col_q == w_max_q);

  assign sram_en   = issue && in_range;
  assign sram_addr = ptr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

`ifdef J_SHIFTER_MC_ZSKIP_EN
  assign pix_zero = pend_zero_q | sram_data[PIX_W];
`else
  logic skip_unused;
  assign skip_unused = sram_data[PIX_W];
  assign pix_zero    = pend_zero_q;
`endif

  assign buf_push  = pend_vld_q;
  assign push_data = pix_zero ? '0 : sram_data[PIX_W-1:0];

  js_pix_buf #(.WIDTH(PIX_W)) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (buf_push),
    .push_data (push_data),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_cnt),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  assign ser_valid = !buf_empty;
  assign accept    = ser_valid && ser_ready;
  assign buf_pop   = accept && (bit_q == BIT_W'(DATA_W - 1));

  // Present the current bit of every lane from the buffer head.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ser_bits = '0;
    if (!buf_empty) begin
      for (int k = 0; k < LANES; k++) ser_bits[k] = buf_head[k*DATA_W + int'(bit_q)];
    end
  end

  // FSM next state; done fires on the DRAIN -> IDLE step.
  always_comb begin
    state_nxt = state_q;
    done_nxt  = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (issue && last_pix) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (buf_pop && (buf_cnt == 2'd1) && !pend_vld_q) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and done pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      done_q  <= done_nxt;
    end
  end

  // Fetch engine: latch config at start, then walk the raster one pixel per issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      offs_q      <= '0;
      w_max_q     <= '0;
      h_max_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      ptr_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_zero_q <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        offs_q  <= offs_start;
        w_max_q <= img_w_m1;
        h_max_q <= img_h_m1;
        col_q   <= '0;
        row_q   <= '0;
        ptr_q   <= ptr_init;
      end else if (issue) begin
        ptr_q <= ptr_q + SRAM_ADDR_W'(1);
        if (col_q == w_max_q) begin
          col_q <= '0;
          row_q <= row_q + DIM_W'(1);
        end else begin
          col_q <= col_q + DIM_W'(1);
        end
      end
      pend_vld_q  <= issue;
      pend_zero_q <= !in_range;
    end
  end

  // Shift engine: bit index within the head pixel, advanced on each accepted beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_q <= '0;
    end else if (accept) begin
      bit_q <= buf_pop ? '0 : bit_q + BIT_W'(1);
    end
  end

endmodule
